// File: rtl/tdm_demux_4ch.sv
// tdm_demux_4ch: bit-interleaved 4-channel TDM demultiplexer.
// Serial stream order is ch0, ch1, ch2, ch3, repeating, one bit per slot, MSB first.
// frame_sync marks the ch0 MSB. One WIDTH-bit word is assembled per channel, and all four
// words are presented together with a one-cycle out_valid pulse.
// Optional build macro TDM_DEMUX_PARITY_EN: each frame is followed by a 4-sample even-parity
// trailer (one bit per channel, in slot order), and a parity_err output is added.
module tdm_demux_4ch #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               din,
    input  logic               din_valid,
    input  logic               frame_sync,
    output logic [4*WIDTH-1:0] out,
    output logic               out_valid,
    output logic               locked,
    output logic               sync_err
`ifdef TDM_DEMUX_PARITY_EN
    ,
    output logic               parity_err
`endif
);

    // Index of the last bit position in a frame: the trailer is one extra position when enabled.
`ifdef TDM_DEMUX_PARITY_EN
    localparam int LAST_I = WIDTH;
`else
    localparam int LAST_I = WIDTH - 1;
`endif
    localparam int BW = $clog2(LAST_I + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(LAST_I);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);

    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state;
    logic [1:0]       slot_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg [0:3];

    logic             at_start;
    logic             at_last;
    logic [4*WIDTH-1:0] frame_word;

    assign at_start = (slot_cnt == 2'd0) && (bit_cnt == '0);
    assign at_last  = (slot_cnt == 2'd3) && (bit_cnt == LAST_BIT);

`ifdef TDM_DEMUX_PARITY_EN
    logic perr_acc;
    logic par_mis;

    // Even parity: the trailer bit must equal the XOR of the channel's data bits.
    assign par_mis    = din ^ (^shreg[slot_cnt]);
    // The last sample is a trailer bit, so the data registers are already complete.
    assign frame_word = {shreg[3], shreg[2], shreg[1], shreg[0]};
`else
    // The last sample is ch3's LSB; fold it in so out sees the complete frame on this edge.
    assign frame_word = {shreg[3][WIDTH-2:0], din, shreg[2], shreg[1], shreg[0]};
`endif

    // Slot tracking, word assembly, frame hand-off and framing-error detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_HUNT;
            slot_cnt  <= 2'd0;
            bit_cnt   <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            locked    <= 1'b0;
            sync_err  <= 1'b0;
            // NOTE: the shift registers are plain flops rather than a RAM, so they can be cleared here alongside the counters.
            for (int k = 0; k < 4; k++) begin
                shreg[k] <= '0;
            end
`ifdef TDM_DEMUX_PARITY_EN
            perr_acc   <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every test here sees pre-edge values.
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
            if (din_valid) begin
                if (state == ST_RUN && at_start && !frame_sync) begin
                    // Expected a frame marker here and did not get one: drop lock and discard the sample.
                    sync_err <= 1'b1;
                    locked   <= 1'b0;
                    state    <= ST_HUNT;
                end else if (frame_sync) begin
                    // A marker always starts a new frame. Mid-frame, the partial frame is abandoned.
                    sync_err <= (state == ST_RUN) && !at_start;
                    state    <= ST_RUN;
                    locked   <= 1'b1;
                    shreg[0] <= {shreg[0][WIDTH-2:0], din};
                    slot_cnt <= 2'd1;
                    bit_cnt  <= '0;
`ifdef TDM_DEMUX_PARITY_EN
                    perr_acc <= 1'b0;
`endif
                end else if (state == ST_RUN) begin
`ifdef TDM_DEMUX_PARITY_EN
                    if (bit_cnt == LAST_BIT) begin
                        perr_acc <= perr_acc | par_mis;
                    end else begin
                        shreg[slot_cnt] <= {shreg[slot_cnt][WIDTH-2:0], din};
                    end
`else
                    shreg[slot_cnt] <= {shreg[slot_cnt][WIDTH-2:0], din};
`endif
                    if (at_last) begin
                        out       <= frame_word;
                        out_valid <= 1'b1;
                        slot_cnt  <= 2'd0;
                        bit_cnt   <= '0;
`ifdef TDM_DEMUX_PARITY_EN
                        parity_err <= perr_acc | par_mis;
`endif
                    end else begin
                        slot_cnt <= slot_cnt + 2'd1;
                        if (slot_cnt == 2'd3) begin
                            bit_cnt <= bit_cnt + BIT_ONE;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// tb_tdm_demux_4ch: self-checking bench for tdm_demux_4ch (default build, WIDTH=4).
// Each frame word is serialised in slot order. A sample-level reference model collects
// samples into a flat frame buffer and de-interleaves it when the frame is complete.
module tb_tdm_demux_4ch;

    localparam int W  = 4;
    localparam int FL = 4 * W;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           din;
    logic           din_valid;
    logic           frame_sync;
    logic [4*W-1:0] out;
    logic           out_valid;
    logic           locked;
    logic           sync_err;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit             m_locked;
    int             m_pos;
    logic [FL-1:0]  m_buf;
    logic [4*W-1:0] m_out;
    bit             m_ov;
    bit             m_se;

    logic [4*W-1:0] fw_a;
    logic [4*W-1:0] fw_b;

    always #5 clk = ~clk;

    tdm_demux_4ch #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .frame_sync(frame_sync),
        .out       (out),
        .out_valid (out_valid),
        .locked    (locked),
        .sync_err  (sync_err)
    );

    // Sample 4*j+k of a frame is bit (W-1-j) of channel k.
    function automatic logic [4*W-1:0] assemble(input logic [FL-1:0] b);
        logic [4*W-1:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < W; j++) begin
                r[W*k + W-1-j] = b[4*j + k];
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        m_locked = 1'b0;
        m_pos    = 0;
        m_buf    = '0;
        m_out    = '0;
        m_ov     = 1'b0;
        m_se     = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic fs, input logic d);
        m_ov = 1'b0;
        m_se = 1'b0;
        if (v) begin
            if (!m_locked) begin
                if (fs) begin
                    m_locked = 1'b1;
                    m_buf[0] = d;
                    m_pos    = 1;
                end
            end else if (fs) begin
                m_se     = (m_pos != 0);
                m_buf[0] = d;
                m_pos    = 1;
            end else if (m_pos == 0) begin
                m_se     = 1'b1;
                m_locked = 1'b0;
            end else begin
                m_buf[m_pos] = d;
                m_pos++;
                if (m_pos == FL) begin
                    m_out = assemble(m_buf);
                    m_ov  = 1'b1;
                    m_pos = 0;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        check({where, ".out"},       64'(out),       64'(m_out));
        check({where, ".out_valid"}, 64'(out_valid), 64'(m_ov));
        check({where, ".locked"},    64'(locked),    64'(m_locked));
        check({where, ".sync_err"},  64'(sync_err),  64'(m_se));
    endtask

    // One clock: drive on the falling edge, let the DUT sample, check just after the rising edge.
    task automatic step(input logic v, input logic fs, input logic d, input string where);
        @(negedge clk);
        din_valid  = v;
        frame_sync = fs;
        din        = d;
        @(posedge clk);
        model_edge(v, fs, d);
        #1;
        check_all(where);
    endtask

    // Serialise the first nsamp samples of frame word fw. Optional stalls carry random junk on din/frame_sync.
    task automatic send_frame(input logic [4*W-1:0] fw, input int nsamp, input int stall_after,
                              input int stall_len, input bit with_sync, input string where);
        for (int i = 0; i < nsamp; i++) begin
            step(1'b1, with_sync && (i == 0), fw[W*(i % 4) + W-1-(i / 4)], where);
            if (stall_after > 0 && ((i + 1) % stall_after) == 0) begin
                for (int s = 0; s < stall_len; s++) begin
                    step(1'b0, 1'($urandom), 1'($urandom), {where, ".stall"});
                end
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        din        = 1'b0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame
        send_frame(16'hC35A, FL, 0, 0, 1'b1, "basic");
        check("basic_out", 64'(out), 64'h0000_0000_0000_C35A);
        check("basic_pulse", 64'(out_valid), 64'd1);

        // Back-to-back frame: ch0..3 = F,0,F,0
        send_frame(16'h0F0F, FL, 0, 0, 1'b1, "b2b");
        check("b2b_out", 64'(out), 64'h0000_0000_0000_0F0F);

        // Stalls: 3 dead cycles after every 2nd sample
        send_frame(16'hC35A, FL, 2, 3, 1'b1, "stall");
        check("stall_out", 64'(out), 64'h0000_0000_0000_C35A);

        // Missing sync at frame start, then relock
        send_frame(16'($urandom), FL, 0, 0, 1'b0, "nosync");
        check("nosync_out", 64'(out), 64'h0000_0000_0000_C35A);
        check("nosync_locked", 64'(locked), 64'd0);
        fw_a = 16'($urandom);
        send_frame(fw_a, FL, 0, 0, 1'b1, "relock");
        check("relock_out", 64'(out), 64'(fw_a));

        // Mid-frame sync at sample 7
        send_frame(16'($urandom), 6, 0, 0, 1'b1, "mid_part");
        fw_b = 16'($urandom);
        send_frame(fw_b, FL, 0, 0, 1'b1, "mid");
        check("mid_out", 64'(out), 64'(fw_b));

        // Randomised traffic: stalls, truncated frames, missing markers
        for (int f = 0; f < 40; f++) begin
            send_frame(16'($urandom),
                       ($urandom_range(0, 5) == 0) ? $urandom_range(1, FL - 1) : FL,
                       $urandom_range(0, 5), $urandom_range(1, 3),
                       $urandom_range(0, 7) != 0, "rand");
        end

        // Reset asserted at sample 10 of a frame
        send_frame(16'($urandom), 9, 0, 0, 1'b1, "prerst");
        @(negedge clk);
        din_valid  = 1'b1;
        frame_sync = 1'b0;
        din        = 1'b1;
        rst_n      = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        @(negedge clk);
        din_valid = 1'b0;
        rst_n     = 1'b1;
        // In HUNT an unmarked sample is ignored, then a full frame locks cleanly.
        step(1'b1, 1'b0, 1'b1, "hunt_discard");
        fw_a = 16'($urandom);
        send_frame(fw_a, FL, 0, 0, 1'b1, "postrst");
        check("postrst_out", 64'(out), 64'(fw_a));
        step(1'b0, 1'b0, 1'b0, "tail");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tdm_demux_4ch.md
Name: tdm_demux_4ch

Overview:
- Receive-side partner of the team's 4:1 channel mux: a bit-interleaved time-division demultiplexer.
- A serial stream carries 4 channels round-robin, one bit per slot. The stream order is ch0, ch1, ch2, ch3, then repeats.
- The block tracks slot position with a frame-sync marker and assembles one WIDTH-bit word per channel.
- It presents all four words together with a one-cycle valid pulse, and sits between the serial link front end and per-channel consumers.

Parameters:
- WIDTH, 8, bits per channel word (legal range 2..32). MSB is sent first.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  1  serial data sample.
- din_valid  input  1  din (and frame_sync) are sampled only when this is 1. When 0, the block stalls.
- frame_sync  input  1  qualified by din_valid. Marks the current sample as slot 0, bit WIDTH-1 of a frame.
- out  output  4*WIDTH  channel words. Channel k is at out[WIDTH*k +: WIDTH].
- out_valid  output  1  one-cycle pulse: out was updated with a complete frame.
- locked  output  1  1 while the block is in the RUN state.
- sync_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (rst_n=0, asynchronous): out=0, out_valid=0, locked=0, sync_err=0. All four shift registers and all counters are cleared, and the state is HUNT. Release of reset is synchronous to clk.
- Internal state: slot_cnt (2 bits, mod 4), bit_cnt (0..WIDTH-1), four WIDTH-bit shift registers.
- A "sample" is a clk edge with din_valid=1. Edges with din_valid=0 change nothing, except that the out_valid and sync_err pulses clear.
- HUNT state:
  - Samples with frame_sync=0 are discarded.
  - A sample with frame_sync=1 is taken as ch0's MSB. The block shifts it into shreg0, sets slot_cnt=1 and bit_cnt=0, enters RUN, and sets locked=1 on the same edge.
- RUN state, normal sample (frame_sync=0, not at frame start):
  - shreg[slot_cnt] is shifted left with din in the LSB.
  - slot_cnt increments. On the 3->0 wrap, bit_cnt increments.
- Frame completion: on the sample where slot_cnt=3 and bit_cnt=WIDTH-1:
  - The bit is shifted into shreg3.
  - On that same edge, out is loaded from all four shift registers, including the new bit, and out_valid is set to 1 for one cycle.
  - slot_cnt and bit_cnt return to 0.
  - Latency: out and out_valid are visible the cycle after the last sample edge.
- Frame start (slot_cnt=0, bit_cnt=0, in RUN):
  - frame_sync=1 is required. The sample is processed as a normal ch0 MSB.
  - If frame_sync=0: sync_err pulses, locked goes to 0, the state returns to HUNT, and the sample is discarded.
- Mid-frame frame_sync=1 (any position other than frame start):
  - sync_err pulses and the partial frame is discarded (the shift registers are not copied to out).
  - The sample is treated as a new ch0 MSB: slot_cnt=1, bit_cnt=0, and the state stays RUN with locked=1.
- out holds the last complete frame until the next completion or reset. It is never partially updated.
- out_valid and sync_err cannot both be 1 on the same cycle by construction.
- Reset asserted mid-frame aborts immediately with no out_valid.

Optional Feature:
- TDM_DEMUX_PARITY_EN defined: each frame is followed by a 4-sample parity trailer, one even-parity bit per channel in slot order.
  - Frame length becomes 4*(WIDTH+1) samples.
  - Adds output parity_err (1 bit, reset 0).
  - out and out_valid update on the last trailer sample, not on the last data sample.
  - parity_err is registered with out_valid and holds its value until the next out_valid. It is 1 if any channel's parity mismatches.
  - frame_sync=1 during the trailer follows the mid-frame rule.
- Undefined: no trailer, no parity_err port, behaviour as described above.

Test Plan:
- Common setup: WIDTH=4, continuous din_valid=1.
- Basic frame: send frame_sync=1 on the first sample, then din bits 1,0,0,1, 0,1,0,1, 1,0,1,0, 0,1,1,0 -> out=16'hC35A, out_valid for exactly one cycle, starting the cycle after the 16th sample; locked=1 from the cycle after the 1st sample.
- Back-to-back frames: a second frame with frame_sync on its first sample, carrying ch0..3 = F,0,F,0 -> out=16'h0F0F one frame later, two out_valid pulses 16 cycles apart, sync_err never asserted.
- Stalls: repeat the basic frame with din_valid=0 inserted for 3 cycles after every 2nd sample -> same out=16'hC35A, out_valid after the 16th valid sample, no state change during the stalls.
- Missing sync: after a good frame, the next frame-start sample has frame_sync=0 -> sync_err pulse, locked=0, out stays 16'hC35A. Then frame_sync=1 plus a full frame -> relock with a correct out.
- Mid-frame sync and reset:
  - frame_sync=1 at sample 7 of a frame -> sync_err pulse, locked stays 1, no out_valid; the following 16 samples starting at that sample yield the correct frame.
  - rst_n low at sample 10 -> all outputs 0 and state HUNT.
